// File: rtl/ex_branch_stage_pkg.sv
// ex_branch_stage_pkg: shared branch funct3 and forward-select encodings
package ex_branch_stage_pkg;
  localparam logic [2:0] BR_EQ = 3'b000;
  localparam logic [2:0] BR_NE = 3'b001;
  localparam logic [2:0] BR_LT = 3'b100;
  localparam logic [2:0] BR_GE = 3'b101;
  localparam logic [2:0] BR_LTU = 3'b110;
  localparam logic [2:0] BR_GEU = 3'b111;
  localparam int FWD_RF = 0;
  localparam int FWD_SRC0 = 1;
endpackage

// File: rtl/ex_branch_stage_br_cond_unit.sv
// br_cond_unit: RV32I branch comparator producing taken condition and illegal-funct3 flag
module br_cond_unit import ex_branch_stage_pkg::*; #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [2:0]      funct3,
  output logic            cond,
  output logic            illegal
);
  always_comb begin
    cond = funct3 == BR_EQ ? a == b :
           funct3 == BR_NE ? a != b :
           funct3 == BR_LT ? $signed(a) < $signed(b) :
           funct3 == BR_GE ? $signed(a) >= $signed(b) :
           funct3 == BR_LTU ? a < b :
           funct3 == BR_GEU ? a >= b : 1'b0;
    illegal = funct3[2:1] == 2'b01;
  end
endmodule

// File: rtl/ex_branch_stage.sv
// ex_branch_stage: EX operand forwarding, branch resolution and EX/MEM slice
module ex_branch_stage import ex_branch_stage_pkg::*; #(
  parameter int XLEN = 32,
  parameter int NFWD = 2,
  parameter int CNT_W = 16,
  localparam int FWD_W = $clog2(NFWD + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 valid_e,
  input  logic                 stall,
  input  logic                 flush,
  input  logic [XLEN-1:0]      rd1,
  input  logic [XLEN-1:0]      rd2,
  input  logic [NFWD*XLEN-1:0] fwd_data,
  input  logic [FWD_W-1:0]     fwd_sel_a,
  input  logic [FWD_W-1:0]     fwd_sel_b,
  input  logic [XLEN-1:0]      imm,
  input  logic [XLEN-1:0]      pc,
  input  logic                 alu_src_b,
  input  logic                 branch,
  input  logic                 jump,
  input  logic                 jump_r,
  input  logic [2:0]           funct3,
  output logic [XLEN-1:0]      src_a,
  output logic [XLEN-1:0]      src_b,
  output logic                 mem_valid,
  output logic [XLEN-1:0]      mem_store_data,
  output logic [XLEN-1:0]      mem_link_pc,
  output logic                 redirect,
  output logic [XLEN-1:0]      redirect_pc,
  output logic                 misalign,
  output logic                 illegal_br,
  output logic [CNT_W-1:0]     taken_cnt
);
  logic [XLEN-1:0] fa, fb, target;
  logic cond, f3_bad, take, bad, illegal;
  always_comb begin
    fa = rd1;
    fb = rd2;
    for (int k = 0; k < NFWD; k++) begin
      fa = fwd_sel_a == FWD_W'(FWD_SRC0 + k) ? fwd_data[k*XLEN +: XLEN] : fa;
      fb = fwd_sel_b == FWD_W'(FWD_SRC0 + k) ? fwd_data[k*XLEN +: XLEN] : fb;
    end
  end
  assign src_a = fa;
  assign src_b = alu_src_b ? imm : fb;
  br_cond_unit #(.XLEN(XLEN)) u_cond (
    .a(fa),
    .b(fb),
    .funct3(funct3),
    .cond(cond),
    .illegal(f3_bad)
  );
  assign target = jump_r ? (fa + imm) & ~XLEN'(1) : pc + imm;
  assign take = valid_e & (jump | (branch & cond));
  assign bad = take & target[1];
  assign illegal = valid_e & branch & f3_bad;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_valid <= 1'b0;
      mem_store_data <= '0;
      mem_link_pc <= '0;
      redirect <= 1'b0;
      redirect_pc <= '0;
      misalign <= 1'b0;
      illegal_br <= 1'b0;
    end else if (flush) begin
      mem_valid <= 1'b0;
      redirect <= 1'b0;
      misalign <= 1'b0;
      illegal_br <= 1'b0;
    end else if (stall) begin
      redirect <= 1'b0;
      misalign <= 1'b0;
      illegal_br <= 1'b0;
    end else begin
      mem_valid <= valid_e;
      mem_store_data <= fb;
      mem_link_pc <= pc + XLEN'(4);
      redirect <= take & ~bad;
      redirect_pc <= target;
      misalign <= bad;
      illegal_br <= illegal;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) taken_cnt <= '0;
    else taken_cnt <= redirect && ~&taken_cnt ? taken_cnt + CNT_W'(1) : taken_cnt;
  end
endmodule

// File: tb/tb_ex_branch_stage.sv
// tb_ex_branch_stage: randomized scoreboard bench for ex_branch_stage
module tb_ex_branch_stage;
  logic clk = 1'b0, rst, valid_e, stall, flush, alu_src_b, branch, jump, jump_r;
  logic [31:0] rd1, rd2, imm, pc, src_a, src_b, mem_store_data, mem_link_pc, redirect_pc;
  logic [31:0] fwd_arr [2];
  logic [63:0] fwd_data;
  logic [1:0] fwd_sel_a, fwd_sel_b;
  logic [2:0] funct3;
  logic mem_valid, redirect, misalign, illegal_br;
  logic [15:0] taken_cnt;
  typedef struct {
    logic mv;
    logic [31:0] sd, lpc, rpc;
    logic rd, mis, ill;
    logic [15:0] cnt;
  } st_t;
  st_t m, q[$];
  int tests = 0, fails = 0;
  assign fwd_data = {fwd_arr[1], fwd_arr[0]};
  always #5 clk = ~clk;
  ex_branch_stage dut (
    .clk(clk), .rst(rst), .valid_e(valid_e), .stall(stall), .flush(flush),
    .rd1(rd1), .rd2(rd2), .fwd_data(fwd_data), .fwd_sel_a(fwd_sel_a), .fwd_sel_b(fwd_sel_b),
    .imm(imm), .pc(pc), .alu_src_b(alu_src_b), .branch(branch), .jump(jump), .jump_r(jump_r),
    .funct3(funct3), .src_a(src_a), .src_b(src_b), .mem_valid(mem_valid),
    .mem_store_data(mem_store_data), .mem_link_pc(mem_link_pc), .redirect(redirect),
    .redirect_pc(redirect_pc), .misalign(misalign), .illegal_br(illegal_br), .taken_cnt(taken_cnt)
  );
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
    end
  endtask
  function automatic logic [31:0] sel(input logic [1:0] s, input logic [31:0] r);
    return (s >= 1 && s <= 2) ? fwd_arr[s-1] : r;
  endfunction
  function automatic logic cond_of(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    case (f)
      3'd0: return a == b;
      3'd1: return a != b;
      3'd4: return $signed(a) < $signed(b);
      3'd5: return $signed(a) >= $signed(b);
      3'd6: return a < b;
      3'd7: return a >= b;
      default: return 1'b0;
    endcase
  endfunction
  task automatic step();
    logic [31:0] a, b, tgt;
    logic take, bad, il;
    st_t n;
    a = sel(fwd_sel_a, rd1);
    b = sel(fwd_sel_b, rd2);
    #1;
    chk("src_a", src_a, a);
    chk("src_b", src_b, alu_src_b ? imm : b);
    tgt = jump_r ? ((a + imm) & 32'hFFFF_FFFE) : pc + imm;
    take = valid_e && (jump || (branch && cond_of(funct3, a, b)));
    bad = take && tgt[1];
    il = valid_e && branch && (funct3 == 3'd2 || funct3 == 3'd3);
    n = m;
    n.cnt = (m.rd && m.cnt != 16'hFFFF) ? m.cnt + 16'd1 : m.cnt;
    if (flush) begin
      n.mv = 0; n.rd = 0; n.mis = 0; n.ill = 0;
    end else if (stall) begin
      n.rd = 0; n.mis = 0; n.ill = 0;
    end else begin
      n.mv = valid_e; n.sd = b; n.lpc = pc + 32'd4; n.rd = take && !bad;
      n.rpc = tgt; n.mis = bad; n.ill = il;
    end
    @(posedge clk);
    m = n;
    q.push_back(n);
    #1;
  endtask
  task automatic idle();
    valid_e = 0; stall = 0; flush = 0; alu_src_b = 0; branch = 0; jump = 0; jump_r = 0;
    funct3 = 0; fwd_sel_a = 0; fwd_sel_b = 0; imm = 0; pc = 32'h100; rd1 = 0; rd2 = 0;
  endtask
  task automatic chk_zero(input string n);
    chk({n, "_mv"}, mem_valid, 0); chk({n, "_sd"}, mem_store_data, 0);
    chk({n, "_lpc"}, mem_link_pc, 0); chk({n, "_rd"}, redirect, 0);
    chk({n, "_rpc"}, redirect_pc, 0); chk({n, "_mis"}, misalign, 0);
    chk({n, "_ill"}, illegal_br, 0); chk({n, "_cnt"}, taken_cnt, 0);
  endtask
  always @(negedge clk) begin
    st_t e;
    if (!rst && q.size() > 0) begin
      e = q.pop_front();
      chk("mem_valid", mem_valid, e.mv);
      chk("redirect", redirect, e.rd);
      chk("misalign", misalign, e.mis);
      chk("illegal_br", illegal_br, e.ill);
      chk("taken_cnt", taken_cnt, e.cnt);
      if (e.mv) begin
        chk("mem_store_data", mem_store_data, e.sd);
        chk("mem_link_pc", mem_link_pc, e.lpc);
        chk("redirect_pc", redirect_pc, e.rpc);
      end
    end
  end
  initial begin
    idle();
    fwd_arr[0] = 0; fwd_arr[1] = 0;
    m = '{default: '0};
    rst = 1;
    #1 chk_zero("reset");
    @(posedge clk); #1 rst = 0;
    rd1 = 5; fwd_arr[0] = 32'h10; fwd_arr[1] = 32'h20; fwd_sel_a = 2;
    step();
    fwd_sel_a = 3;
    step();
    chk("fwd_sel3", src_a, 32'd5);
    fwd_arr[0] = 32'hFFFF_FFFF; fwd_arr[1] = 1; fwd_sel_a = 1; fwd_sel_b = 2;
    valid_e = 1; branch = 1; funct3 = 3'b100; imm = 32'h40;
    step();
    funct3 = 3'b110;
    step();
    idle(); valid_e = 1; jump = 1; jump_r = 1; rd1 = 32'h1003; pc = 32'h200;
    step();
    rd1 = 32'h1001;
    step();
    idle(); valid_e = 1; branch = 1; rd1 = 7; rd2 = 7; imm = 32'h80; stall = 1;
    repeat (3) step();
    stall = 0;
    step();
    idle();
    repeat (2) step();
    valid_e = 1; jump = 1; imm = 32'h10; flush = 1; stall = 1;
    step();
    idle();
    step();
    for (int i = 0; i < 400; i++) begin
      int r;
      valid_e = $urandom_range(0, 7) != 0;
      stall = $urandom_range(0, 3) == 0;
      flush = $urandom_range(0, 9) == 0;
      rd1 = $urandom;
      rd2 = $urandom_range(0, 1) ? rd1 : $urandom;
      fwd_arr[0] = $urandom_range(0, 3) == 0 ? rd1 : $urandom;
      fwd_arr[1] = $urandom;
      fwd_sel_a = 2'($urandom_range(0, 3));
      fwd_sel_b = 2'($urandom_range(0, 3));
      imm = $urandom_range(0, 1) ? $urandom : ($urandom & 32'hFFE);
      pc = $urandom & 32'hFFFF_FFFC;
      alu_src_b = 1'($urandom_range(0, 1));
      r = $urandom_range(0, 3);
      branch = r == 1; jump = r >= 2; jump_r = r == 3;
      funct3 = 3'($urandom_range(0, 7));
      step();
    end
    idle();
    #1 rst = 1;
    #1 chk_zero("async_rst");
    q.delete();
    m = '{default: '0};
    valid_e = 1; jump = 1; stall = 1; imm = 32'h20;
    @(posedge clk); #1 rst = 0;
    step();
    idle(); valid_e = 1; branch = 1; funct3 = 3'b010;
    step();
    idle(); valid_e = 1; jump = 1; imm = 32'h8;
    repeat (65540) step();
    idle();
    repeat (2) step();
    chk("saturate", taken_cnt, 32'hFFFF);
    repeat (2) @(negedge clk);
    chk("drain", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
